// File: rtl/bp_common_pkg.sv
// bp_common_pkg
// Shared types and configuration helpers for the BlackParrot PCE fill path.
//   bp_params_e          : processor configuration selector
//   bp_pce_fill_state_e  : fill assembler FSM state
//   bp_pce_fill_err_e    : fill error cause (none / short / long)
//   icache_fill_width()  : I-cache fill width in bits for a configuration
//   dcache_fill_width()  : D-cache fill width in bits for a configuration
package bp_common_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_small_cfg,
        e_bp_wide_cfg
    } bp_params_e;

    typedef enum logic [1:0] {
        e_collect,
        e_drain,
        e_send
    } bp_pce_fill_state_e;

    typedef enum logic [1:0] {
        e_fill_err_none,
        e_fill_err_short,
        e_fill_err_long
    } bp_pce_fill_err_e;

    function automatic int icache_fill_width(bp_params_e cfg);
        case (cfg)
            e_bp_small_cfg: return 128;
            e_bp_wide_cfg:  return 512;
            default:        return 256;
        endcase
    endfunction

    function automatic int dcache_fill_width(bp_params_e cfg);
        case (cfg)
            e_bp_small_cfg: return 128;
            e_bp_wide_cfg:  return 512;
            default:        return 256;
        endcase
    endfunction

endpackage

// File: rtl/bp_pce_fill_assembler_slot_rotate.sv
// bp_pce_fill_assembler_slot_rotate
// Maps the running beat count onto a fill-line slot index.
// Configuration macro: BP_PCE_CRITICAL_WORD_FIRST_EN
//   defined   : slot = (offset + cnt) mod N, so the first beat (critical word)
//               lands in the requested word position
//   undefined : slot = cnt, offset is ignored
// Ports:
//   cnt_i    in  lg_n_p  beats already written for the current fill
//   offset_i in  lg_n_p  requested critical-word index
//   slot_o   out lg_n_p  slot the current beat is written to
module bp_pce_fill_assembler_slot_rotate #(
    parameter int n_p    = 4,
    parameter int lg_n_p = 2
) (
    input  logic [lg_n_p-1:0] cnt_i,
    input  logic [lg_n_p-1:0] offset_i,
    output logic [lg_n_p-1:0] slot_o
);

`ifdef BP_PCE_CRITICAL_WORD_FIRST_EN
    // One extra bit holds offset+cnt (< 2N), so a single conditional
    // subtract gives the modulo even when N is not a power of two.
    logic [lg_n_p:0] sum;

    always_comb begin
        sum = {1'b0, offset_i} + {1'b0, cnt_i};
        if (sum >= (lg_n_p+1)'(n_p)) begin
            sum = sum - (lg_n_p+1)'(n_p);
        end
        slot_o = sum[lg_n_p-1:0];
    end
`else
    logic unused_offset;

    assign unused_offset = ^offset_i;
    assign slot_o        = cnt_i;
`endif

endmodule

// File: rtl/bp_pce_fill_assembler.sv
// bp_pce_fill_assembler
// Collects N = fill_width_p/beat_width_p memory response beats into one cache
// fill line and presents it to the consumer with a valid/yumi handshake.
// Short responses are zero-padded, long responses are truncated to N beats
// with the remainder drained; both flag fill_err_o.
// Configuration macro: BP_PCE_CRITICAL_WORD_FIRST_EN (critical-word-first slot
// rotation, see bp_pce_fill_assembler_slot_rotate).
// Ports:
//   clk_i            in   1             clock, rising edge
//   reset_n_i        in   1             asynchronous active-low reset
//   beat_i           in   beat_width_p  response data beat
//   beat_v_i         in   1             beat valid
//   beat_last_i      in   1             final beat of the response
//   beat_offset_i    in   lg(N)         critical word index, first beat only
//   beat_ready_and_o out  1             beat accepted when valid & ready
//   fill_data_o      out  fill_width_p  assembled fill line (registered)
//   fill_v_o         out  1             fill line valid
//   fill_err_o       out  1             beat count mismatch, qualified by fill_v_o
//   fill_yumi_i      in   1             consumer takes the fill
// fill_width_p defaults to the I-cache fill width of the chosen config; a
// D-side instance passes dcache_fill_width(bp_params_p) instead.
module bp_pce_fill_assembler
    import bp_common_pkg::*;
#(
    parameter bp_params_e bp_params_p  = e_bp_default_cfg,
    parameter int         beat_width_p = 64,
    parameter int         fill_width_p = icache_fill_width(bp_params_p),
    localparam int        n_lp         = fill_width_p / beat_width_p,
    localparam int        lg_n_lp      = (n_lp > 1) ? $clog2(n_lp) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [beat_width_p-1:0] beat_i,
    input  logic                    beat_v_i,
    input  logic                    beat_last_i,
    input  logic [lg_n_lp-1:0]      beat_offset_i,
    output logic                    beat_ready_and_o,
    output logic [fill_width_p-1:0] fill_data_o,
    output logic                    fill_v_o,
    output logic                    fill_err_o,
    input  logic                    fill_yumi_i
);

    localparam logic [lg_n_lp-1:0] last_cnt_lp = lg_n_lp'(n_lp - 1);

    bp_pce_fill_state_e      state_q, state_d;
    bp_pce_fill_err_e        err_q, err_d;
    logic [lg_n_lp-1:0]      cnt_q, cnt_d;
    logic [lg_n_lp-1:0]      offset_q, offset_d;
    logic [fill_width_p-1:0] data_q, data_d;
    logic [lg_n_lp-1:0]      rot_offset;
    logic [lg_n_lp-1:0]      slot;

    // The first beat has no latched offset yet, so it uses the live input.
    assign rot_offset = (cnt_q == '0) ? beat_offset_i : offset_q;

    bp_pce_fill_assembler_slot_rotate #(
        .n_p    (n_lp),
        .lg_n_p (lg_n_lp)
    ) u_slot_rotate (
        .cnt_i    (cnt_q),
        .offset_i (rot_offset),
        .slot_o   (slot)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        data_d   = data_q;

        case (state_q)
            e_collect: begin
                if (beat_v_i) begin
                    data_d[int'(slot)*beat_width_p +: beat_width_p] = beat_i;
                    cnt_d = (cnt_q == last_cnt_lp) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        offset_d = beat_offset_i;
                    end
                    if (beat_last_i) begin
                        state_d = e_send;
                        err_d   = (cnt_q == last_cnt_lp) ? e_fill_err_none
                                                         : e_fill_err_short;
                    end else if (cnt_q == last_cnt_lp) begin
                        state_d = e_drain;
                        err_d   = e_fill_err_long;
                    end
                end
            end
            e_drain: begin
                if (beat_v_i && beat_last_i) begin
                    state_d = e_send;
                end
            end
            e_send: begin
                if (fill_yumi_i) begin
                    state_d  = e_collect;
                    err_d    = e_fill_err_none;
                    cnt_d    = '0;
                    offset_d = '0;
                    data_d   = '0;
                end
            end
            default: begin
                state_d = e_collect;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_collect;
            err_q    <= e_fill_err_none;
            cnt_q    <= '0;
            offset_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
            data_q   <= data_d;
        end
    end

    assign beat_ready_and_o = (state_q != e_send);
    assign fill_v_o         = (state_q == e_send);
    assign fill_err_o       = fill_v_o && (err_q != e_fill_err_none);
    assign fill_data_o      = data_q;

endmodule

// File: tb/tb_bp_pce_fill_assembler.sv
module tb_bp_pce_fill_assembler;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [63:0]  beat_i;
    logic         beat_v_i;
    logic         beat_last_i;
    logic [1:0]   beat_offset_i;
    logic         beat_ready_and_o;
    logic [255:0] fill_data_o;
    logic         fill_v_o;
    logic         fill_err_o;
    logic         fill_yumi_i;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] va, vb, vc, vd, ve, vf;
    logic [255:0] exp_cw;

    always #5 clk_i = ~clk_i;

    bp_pce_fill_assembler dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .beat_i           (beat_i),
        .beat_v_i         (beat_v_i),
        .beat_last_i      (beat_last_i),
        .beat_offset_i    (beat_offset_i),
        .beat_ready_and_o (beat_ready_and_o),
        .fill_data_o      (fill_data_o),
        .fill_v_o         (fill_v_o),
        .fill_err_o       (fill_err_o),
        .fill_yumi_i      (fill_yumi_i)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    // Presents one beat on the falling edge; it is accepted on the next rising edge.
    task automatic send_beat(input logic [63:0] d, input logic last, input logic [1:0] off);
        @(negedge clk_i);
        beat_i        = d;
        beat_v_i      = 1'b1;
        beat_last_i   = last;
        beat_offset_i = off;
        @(posedge clk_i);
        #1;
        beat_v_i    = 1'b0;
        beat_last_i = 1'b0;
    endtask

    task automatic take_fill();
        @(negedge clk_i);
        fill_yumi_i = 1'b1;
        @(posedge clk_i);
        #1;
        fill_yumi_i = 1'b0;
    endtask

    initial begin
        va = 64'hAAAA_0000_0000_000A;
        vb = 64'hBBBB_0000_0000_000B;
        vc = 64'hCCCC_0000_0000_000C;
        vd = 64'hDDDD_0000_0000_000D;
        ve = 64'hEEEE_0000_0000_000E;
        vf = 64'hFFFF_0000_0000_000F;

        reset_n_i     = 1'b0;
        beat_i        = '0;
        beat_v_i      = 1'b0;
        beat_last_i   = 1'b0;
        beat_offset_i = '0;
        fill_yumi_i   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_fill_v", fill_v_o, 1'b0);
        check("rst_fill_err", fill_err_o, 1'b0);
        check("rst_fill_data", fill_data_o, 256'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        check("rst_ready", beat_ready_and_o, 1'b1);

        // Full 4-beat fill
        send_beat(va, 1'b0, 2'd0);
        send_beat(vb, 1'b0, 2'd0);
        send_beat(vc, 1'b0, 2'd0);
        check("full_v_before_last", fill_v_o, 1'b0);
        check("full_ready_collect", beat_ready_and_o, 1'b1);
        send_beat(vd, 1'b1, 2'd0);
        check("full_v", fill_v_o, 1'b1);
        check("full_data", fill_data_o, {vd, vc, vb, va});
        check("full_err", fill_err_o, 1'b0);
        check("full_ready_send", beat_ready_and_o, 1'b0);
        take_fill();
        check("full_v_after_yumi", fill_v_o, 1'b0);
        check("full_ready_after_yumi", beat_ready_and_o, 1'b1);
        check("full_data_cleared", fill_data_o, 256'd0);

        // Short fill: last on 2nd beat
        send_beat(va, 1'b0, 2'd0);
        send_beat(vb, 1'b1, 2'd0);
        check("short_v", fill_v_o, 1'b1);
        check("short_data", fill_data_o, {64'd0, 64'd0, vb, va});
        check("short_err", fill_err_o, 1'b1);
        take_fill();
        check("short_err_after_yumi", fill_err_o, 1'b0);

        // Long fill: six beats, last on the 6th
        send_beat(va, 1'b0, 2'd0);
        send_beat(vb, 1'b0, 2'd0);
        send_beat(vc, 1'b0, 2'd0);
        send_beat(vd, 1'b0, 2'd0);
        check("long_v_drain4", fill_v_o, 1'b0);
        check("long_ready_drain4", beat_ready_and_o, 1'b1);
        send_beat(ve, 1'b0, 2'd0);
        check("long_v_drain5", fill_v_o, 1'b0);
        check("long_ready_drain5", beat_ready_and_o, 1'b1);
        send_beat(vf, 1'b1, 2'd0);
        check("long_v", fill_v_o, 1'b1);
        check("long_data", fill_data_o, {vd, vc, vb, va});
        check("long_err", fill_err_o, 1'b1);
        take_fill();

        // Consumer stall with beats pending
        send_beat(va, 1'b0, 2'd0);
        send_beat(vb, 1'b0, 2'd0);
        send_beat(vc, 1'b0, 2'd0);
        send_beat(vd, 1'b1, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            beat_i      = ve;
            beat_v_i    = 1'b1;
            fill_yumi_i = 1'b0;
            @(posedge clk_i);
            #1;
            check($sformatf("stall_ready_%0d", i), beat_ready_and_o, 1'b0);
            check($sformatf("stall_v_%0d", i), fill_v_o, 1'b1);
            check($sformatf("stall_data_%0d", i), fill_data_o, {vd, vc, vb, va});
        end
        @(negedge clk_i);
        beat_v_i    = 1'b0;
        fill_yumi_i = 1'b1;
        @(posedge clk_i);
        #1;
        fill_yumi_i = 1'b0;
        check("stall_ready_after_yumi", beat_ready_and_o, 1'b1);
        check("stall_v_after_yumi", fill_v_o, 1'b0);

        // Reset mid-collect, then a clean packet
        send_beat(va, 1'b0, 2'd0);
        send_beat(vb, 1'b0, 2'd0);
        reset_n_i = 1'b0;
        #1;
        check("rstc_data", fill_data_o, 256'd0);
        check("rstc_v", fill_v_o, 1'b0);
        check("rstc_err", fill_err_o, 1'b0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        send_beat(vc, 1'b0, 2'd0);
        send_beat(vd, 1'b0, 2'd0);
        send_beat(ve, 1'b0, 2'd0);
        check("rstc_v_before_last", fill_v_o, 1'b0);
        send_beat(vf, 1'b1, 2'd0);
        check("rstc_fresh_v", fill_v_o, 1'b1);
        check("rstc_fresh_data", fill_data_o, {vf, ve, vd, vc});
        check("rstc_fresh_err", fill_err_o, 1'b0);
        take_fill();

        // Reset while a fill is pending
        send_beat(va, 1'b0, 2'd0);
        send_beat(vb, 1'b0, 2'd0);
        send_beat(vc, 1'b0, 2'd0);
        send_beat(vd, 1'b1, 2'd0);
        check("rsts_v_pending", fill_v_o, 1'b1);
        reset_n_i = 1'b0;
        #1;
        check("rsts_v", fill_v_o, 1'b0);
        check("rsts_data", fill_data_o, 256'd0);
        check("rsts_ready", beat_ready_and_o, 1'b1);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("rsts_no_pulse_%0d", i), fill_v_o, 1'b0);
        end

        // Critical-word offset on the first beat only
`ifdef BP_PCE_CRITICAL_WORD_FIRST_EN
        exp_cw = {vb, va, vd, vc};
`else
        exp_cw = {vd, vc, vb, va};
`endif
        send_beat(va, 1'b0, 2'd2);
        send_beat(vb, 1'b0, 2'd0);
        send_beat(vc, 1'b0, 2'd1);
        send_beat(vd, 1'b1, 2'd3);
        check("cwf_v", fill_v_o, 1'b1);
        check("cwf_data", fill_data_o, exp_cw);
        check("cwf_err", fill_err_o, 1'b0);
        take_fill();
        check("cwf_v_after_yumi", fill_v_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
